// File: rtl/exp_golomb_encoder.sv
// Order-0 Exp-Golomb serializer.
// Takes one DATA_WIDTH-bit value per handshake and emits N zeros followed by
// x[N:0], MSB first, where x = value + 1. Each codeword is followed by an
// idle gap so a downstream decoder can return to its counting state.
module exp_golomb_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  dft_tm_i,
    input  logic [DATA_WIDTH-1:0] dt_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  dt_o,
    output logic                  valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ZEROS = 2'd1,
        S_BITS  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH:0]   x_reg;
    logic [DATA_WIDTH:0]   x_next;
    logic [ADDR_WIDTH-1:0] n_next;
    logic [ADDR_WIDTH-1:0] cnt_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;
    logic [ADDR_WIDTH-1:0] idx_dec;
    logic                  dt_reg;
    logic                  valid_reg;
    logic                  rstn_b_w;

    // In test mode the reset pin is masked so scan shifting cannot clear state.
    assign rstn_b_w = dft_tm_i ? 1'b1 : rstn_i;

    // Extend by one bit so the all-ones input does not wrap.
    assign x_next  = {1'b0, dt_i} + (DATA_WIDTH+1)'(1);
    assign idx_dec = idx_reg - ADDR_WIDTH'(1);

    // Priority chain: each stage overrides the lower result when its bit is set,
    // so the last stage holds the index of the most significant 1.
    logic [ADDR_WIDTH-1:0] msb_pos_w [DATA_WIDTH+1];
    assign msb_pos_w[0] = '0;
    generate
        for (genvar gi = 1; gi <= DATA_WIDTH; gi++) begin : g_msb
            assign msb_pos_w[gi] = x_next[gi] ? ADDR_WIDTH'(gi) : msb_pos_w[gi-1];
        end
    endgenerate
    assign n_next = msb_pos_w[DATA_WIDTH];

    assign ready_o = (state_reg == S_IDLE);
    assign dt_o    = dt_reg;
    assign valid_o = valid_reg;

    // Control FSM; the outputs registered here describe the bit shown during
    // the state being entered, so the first bit appears right after accept.
    always_ff @(posedge clk_i or negedge rstn_b_w) begin
        if (!rstn_b_w) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            dt_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    dt_reg    <= 1'b0;
                    valid_reg <= 1'b0;
                    if (valid_i) begin
                        x_reg     <= x_next;
                        valid_reg <= 1'b1;
                        idx_reg   <= n_next;
                        if (n_next != '0) begin
                            // cnt holds zeros still to send after the current one
                            state_reg <= S_ZEROS;
                            cnt_reg   <= n_next - ADDR_WIDTH'(1);
                            dt_reg    <= 1'b0;
                        end else begin
                            state_reg <= S_BITS;
                            dt_reg    <= x_next[0];
                        end
                    end
                end
                S_ZEROS: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_BITS;
                        dt_reg    <= x_reg[idx_reg];
                    end else begin
                        cnt_reg <= cnt_reg - ADDR_WIDTH'(1);
                    end
                end
                S_BITS: begin
                    if (idx_reg == '0) begin
                        state_reg <= S_GAP;
                        cnt_reg   <= ADDR_WIDTH'(GAP_CYCLES - 1);
                        dt_reg    <= 1'b0;
                        valid_reg <= 1'b0;
                    end else begin
                        idx_reg <= idx_dec;
                        dt_reg  <= x_reg[idx_dec];
                    end
                end
                S_GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    dt_reg    <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
